// File: rtl/hex_disp_pkg.sv
// Shared constants and the nibble-to-segment decode table for the hex display driver.
package hex_disp_pkg;

  localparam int NUM_DIGITS = 6;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low a..g pattern, bit0 = a, bit6 = g.
  function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// One digit: nibble decode with optional blanking, decimal point appended as bit7.
module hex_to_seg
  import hex_disp_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] seg
);

  always_comb begin
    seg      = SEG_BLANK;
    seg[6:0] = blank ? SEG_BLANK[6:0] : seg_decode(nibble);
    seg[7]   = ~dp;
  end

endmodule

// File: rtl/hex_display_driver.sv
// Six-digit active-low seven-segment driver with load shadowing, blinking and enable.
// Optional leading-zero blanking is built when HEX_LZB_EN is defined.
module hex_display_driver
  import hex_disp_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int BLINK_HZ = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [23:0] value,
  input  logic [5:0]  dp,
  input  logic [5:0]  blink_mask,
  input  logic        en,
  output logic        load_ack,
  output logic [7:0]  HEX0,
  output logic [7:0]  HEX1,
  output logic [7:0]  HEX2,
  output logic [7:0]  HEX3,
  output logic [7:0]  HEX4,
  output logic [7:0]  HEX5
);

  localparam int HALF  = CLK_HZ / (2 * BLINK_HZ);
  localparam int CNT_W = (HALF >= 2) ? $clog2(HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);

  generate
    if (HALF < 2) begin : g_bad_half
      $error("hex_display_driver: CLK_HZ/(2*BLINK_HZ) must be at least 2");
    end
  endgenerate

  logic [23:0]                 val_q, val_d;
  logic [5:0]                  dp_q, dp_d;
  logic [5:0]                  bm_q, bm_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        phase_q, phase_d;
  logic                        ack_q, ack_d;
  logic [NUM_DIGITS-1:0][7:0]  hex_q, hex_d;
  logic [NUM_DIGITS-1:0][7:0]  seg_w;
  logic [NUM_DIGITS-1:0]       lzb_blank;

`ifdef HEX_LZB_EN
  logic lzb_run;

  // A digit is blanked when it and every digit above it are zero; HEX0 always shows.
  always_comb begin
    lzb_blank = '0;
    lzb_run   = 1'b1;
    for (int n = NUM_DIGITS - 1; n >= 1; n--) begin
      lzb_run      = lzb_run && (val_q[4*n +: 4] == 4'h0);
      lzb_blank[n] = lzb_run;
    end
  end
`else
  assign lzb_blank = '0;
`endif

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    hex_to_seg u_seg (
      .nibble (val_q[4*g +: 4]),
      .dp     (dp_q[g]),
      .blank  (lzb_blank[g]),
      .seg    (seg_w[g])
    );
  end

  // load/load_ack: no back-pressure; every edge with load=1 captures value/dp/blink_mask,
  // and load_ack is high for exactly the cycle following each capturing edge.
  always_comb begin
    val_d   = load ? value      : val_q;
    dp_d    = load ? dp         : dp_q;
    bm_d    = load ? blink_mask : bm_q;
    ack_d   = load;
    cnt_d   = cnt_q + CNT_W'(1);
    phase_d = phase_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
    for (int n = 0; n < NUM_DIGITS; n++) begin
      hex_d[n] = seg_w[n];
      if (!en || (bm_q[n] && phase_q)) hex_d[n] = SEG_BLANK;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q   <= '0;
      dp_q    <= '0;
      bm_q    <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      ack_q   <= 1'b0;
      hex_q   <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      val_q   <= val_d;
      dp_q    <= dp_d;
      bm_q    <= bm_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      ack_q   <= ack_d;
      hex_q   <= hex_d;
    end
  end

  assign load_ack = ack_q;
  assign HEX0     = hex_q[0];
  assign HEX1     = hex_q[1];
  assign HEX2     = hex_q[2];
  assign HEX3     = hex_q[3];
  assign HEX4     = hex_q[4];
  assign HEX5     = hex_q[5];

endmodule

// File: tb/tb_hex_display_driver.sv
// Directed bench for hex_display_driver with CLK_HZ=8, BLINK_HZ=1 (blink half-period 4 clocks).
module tb_hex_display_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [23:0] value;
  logic [5:0]  dp;
  logic [5:0]  blink_mask;
  logic        en;
  logic        load_ack;
  wire  [7:0]  hex_o [6];

  int total = 0;
  int bad   = 0;
  int ecount;

  typedef struct {
    logic [23:0]      value;
    logic [5:0]       dp;
    logic [5:0][7:0]  exp;
  } vec_t;

  vec_t vecs [5];

  hex_display_driver #(.CLK_HZ(8), .BLINK_HZ(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .value      (value),
    .dp         (dp),
    .blink_mask (blink_mask),
    .en         (en),
    .load_ack   (load_ack),
    .HEX0       (hex_o[0]),
    .HEX1       (hex_o[1]),
    .HEX2       (hex_o[2]),
    .HEX3       (hex_o[3]),
    .HEX4       (hex_o[4]),
    .HEX5       (hex_o[5])
  );

  // Clock / reset-relative edge counter (k = edges since reset release).
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) ecount <= 0;
    else     ecount <= ecount + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [23:0] v, input logic [5:0] d, input logic [5:0] bm);
    load       = 1'b1;
    value      = v;
    dp         = d;
    blink_mask = bm;
    tick();
    load = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_h;
    logic [7:0] dec0;
    logic [7:0] dec2;
    rst = 1'b1; load = 1'b0; value = '0; dp = '0; blink_mask = '0; en = 1'b1;

    vecs[0] = '{24'h012345, 6'b000000,
`ifdef HEX_LZB_EN
                {8'hFF, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92}};
`else
                {8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92}};
`endif
    vecs[1] = '{24'hFEDCBA, 6'b000001, {8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h08}};
    vecs[2] = '{24'h000000, 6'b100000,
`ifdef HEX_LZB_EN
                {8'h7F, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0}};
`else
                {8'h40, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0}};
`endif
    vecs[3] = '{24'h987654, 6'b101010, {8'h10, 8'h80, 8'h78, 8'h82, 8'h12, 8'h99}};
    vecs[4] = '{24'h00A000, 6'b000100,
`ifdef HEX_LZB_EN
                {8'hFF, 8'hFF, 8'h88, 8'h40, 8'hC0, 8'hC0}};
`else
                {8'hC0, 8'hC0, 8'h88, 8'h40, 8'hC0, 8'hC0}};
`endif

    // Reset state
    #2;
    for (int n = 0; n < 6; n++) chk($sformatf("reset hex%0d", n), 32'(hex_o[n]), 32'hFF);
    chk("reset ack", 32'(load_ack), 32'h0);
    tick(); tick();
    rst = 1'b0;

    // Table: load, ack one cycle later, display two clocks after load edge
    for (int i = 0; i < 5; i++) begin
      do_load(vecs[i].value, vecs[i].dp, 6'b0);
      chk($sformatf("vec%0d ack", i), 32'(load_ack), 32'h1);
      tick();
      chk($sformatf("vec%0d ack_low", i), 32'(load_ack), 32'h0);
      for (int n = 0; n < 6; n++)
        chk($sformatf("vec%0d hex%0d", i, n), 32'(hex_o[n]), 32'(vecs[i].exp[n]));
    end

    // Blink on HEX0/HEX1 only; phase flips every 4 edges after reset release
    do_load(24'h012345, 6'b0, 6'b000011);
    tick();
    dec0 = 8'h92;
    dec2 = 8'hB0;
    for (int c = 0; c < 12; c++) begin
      exp_h = (((ecount - 1) / 4) % 2 == 1) ? 8'hFF : dec0;
      chk($sformatf("blink%0d hex0", c), 32'(hex_o[0]), 32'(exp_h));
      exp_h = (((ecount - 1) / 4) % 2 == 1) ? 8'hFF : 8'h99;
      chk($sformatf("blink%0d hex1", c), 32'(hex_o[1]), 32'(exp_h));
      chk($sformatf("blink%0d hex2", c), 32'(hex_o[2]), 32'(dec2));
      tick();
    end

    // Enable off blanks everything next clock; on restores without reload
    do_load(24'h012345, 6'b000010, 6'b0);
    tick();
    en = 1'b0;
    tick();
    for (int n = 0; n < 6; n++) chk($sformatf("en_off hex%0d", n), 32'(hex_o[n]), 32'hFF);
    tick();
    chk("en_off hold hex1", 32'(hex_o[1]), 32'hFF);
    en = 1'b1;
    tick();
    chk("en_on hex0", 32'(hex_o[0]), 32'h92);
    chk("en_on hex1", 32'(hex_o[1]), 32'h19);
    chk("en_on hex4", 32'(hex_o[4]), 32'hF9);

    // Asynchronous reset mid-cycle while displaying 111111 with ack high
    do_load(24'h111111, 6'b0, 6'b0);
    tick();
    chk("pre_rst hex0", 32'(hex_o[0]), 32'hF9);
    do_load(24'h111111, 6'b0, 6'b0);
    chk("pre_rst ack", 32'(load_ack), 32'h1);
    #3;
    rst = 1'b1;
    #1;
    for (int n = 0; n < 6; n++) chk($sformatf("async_rst hex%0d", n), 32'(hex_o[n]), 32'hFF);
    chk("async_rst ack", 32'(load_ack), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    for (int n = 0; n < 6; n++) begin
`ifdef HEX_LZB_EN
      exp_h = (n == 0) ? 8'hC0 : 8'hFF;
`else
      exp_h = 8'hC0;
`endif
      chk($sformatf("post_rst hex%0d", n), 32'(hex_o[n]), 32'(exp_h));
    end

    // Load on the first edge after reset release
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    do_load(24'h000007, 6'b0, 6'b0);
    chk("first_edge ack", 32'(load_ack), 32'h1);
    tick();
    chk("first_edge hex0", 32'(hex_o[0]), 32'hF8);

    // Back-to-back loads
    load = 1'b1; value = 24'h000001; dp = '0; blink_mask = '0;
    tick();
    chk("b2b ack1", 32'(load_ack), 32'h1);
    value = 24'h000002;
    tick();
    load = 1'b0;
    chk("b2b ack2", 32'(load_ack), 32'h1);
    chk("b2b hex0 first", 32'(hex_o[0]), 32'hF9);
    tick();
    chk("b2b hex0 second", 32'(hex_o[0]), 32'hA4);
    chk("b2b ack_low", 32'(load_ack), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
